// File: rtl/mux_nto1_pipe.sv
// N-input, W-bit select with one registered output stage and a 2-entry skid buffer.
// Out-of-range selects fall back to the last input and travel with an error flag.
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] outData_q;
  logic [WIDTH-1:0] skidData_q;
  logic             outErr_q;
  logic             skidErr_q;
  logic [WIDTH-1:0] selWord;
  logic             selErr;
  logic             acc;
  logic             pop;

  // Default is the out-of-range fallback; a matching in-range index overrides it.
  always_comb begin
    selWord = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
    selErr  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(in_sel) == k) begin
        selWord = in_data[k*WIDTH +: WIDTH];
        selErr  = 1'b0;
      end
    end
  end

  assign in_ready  = reset_n & (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = outData_q;
  assign out_err   = outErr_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      outData_q  <= '0;
      outErr_q   <= 1'b0;
      skidData_q <= '0;
      skidErr_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_q   <= ONE;
            outData_q <= selWord;
            outErr_q  <= selErr;
          end
        end
        ONE: begin
          if (acc && pop) begin
            outData_q <= selWord;
            outErr_q  <= selErr;
          end else if (acc) begin
            // Consumer stalled: park the new word behind the one on the output.
            state_q    <= FULL;
            skidData_q <= selWord;
            skidErr_q  <= selErr;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_q   <= ONE;
            outData_q <= skidData_q;
            outErr_q  <= skidErr_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: vector tables, backpressure, streaming
// against a queue model, and reset with words in flight.
module tb_mux_nto1_pipe;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  logic         clk;
  logic         resetN;
  logic [255:0] inData;
  logic [2:0]   inSel;
  logic         inValid;
  logic         inReady;
  logic [31:0]  outData;
  logic         outErr;
  logic         outValid;
  logic         outReady;

  logic [159:0] inData5;
  logic [2:0]   inSel5;
  logic         inValid5;
  logic         inReady5;
  logic [31:0]  outData5;
  logic         outErr5;
  logic         outValid5;
  logic         outReady5;

  int nCompared;
  int nMismatched;

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) dut (
    .clk(clk), .reset_n(resetN), .in_data(inData), .in_sel(inSel),
    .in_valid(inValid), .in_ready(inReady), .out_data(outData),
    .out_err(outErr), .out_valid(outValid), .out_ready(outReady)
  );

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) dut5 (
    .clk(clk), .reset_n(resetN), .in_data(inData5), .in_sel(inSel5),
    .in_valid(inValid5), .in_ready(inReady5), .out_data(outData5),
    .out_err(outErr5), .out_valid(outValid5), .out_ready(outReady5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic r);
    inValid  = v;
    inSel    = s;
    outReady = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic loadSweepData();
    for (int k = 0; k < 8; k++) inData[k*32 +: 32] = 32'h1000_0000 + k;
  endtask

  vec_t sweepVecs[10];
  vec_t oorVecs[5];
  logic [32:0] sbQ[$];
  logic [32:0] expWord;

  initial begin
    int sent;
    int received;
    int cycles;
    logic acc;
    logic pop;

    nCompared   = 0;
    nMismatched = 0;

    sweepVecs[0] = '{3'd0, 32'h1000_0000, 1'b0};
    sweepVecs[1] = '{3'd1, 32'h1000_0001, 1'b0};
    sweepVecs[2] = '{3'd2, 32'h1000_0002, 1'b0};
    sweepVecs[3] = '{3'd3, 32'h1000_0003, 1'b0};
    sweepVecs[4] = '{3'd4, 32'h1000_0004, 1'b0};
    sweepVecs[5] = '{3'd5, 32'h1000_0005, 1'b0};
    sweepVecs[6] = '{3'd6, 32'h1000_0006, 1'b0};
    sweepVecs[7] = '{3'd7, 32'h1000_0007, 1'b0};
    sweepVecs[8] = '{3'd3, 32'h1000_0003, 1'b0};
    sweepVecs[9] = '{3'd5, 32'h1000_0005, 1'b0};

    oorVecs[0] = '{3'd6, 32'hDEAD_BEEF, 1'b1};
    oorVecs[1] = '{3'd2, 32'hA000_0002, 1'b0};
    oorVecs[2] = '{3'd5, 32'hDEAD_BEEF, 1'b1};
    oorVecs[3] = '{3'd7, 32'hDEAD_BEEF, 1'b1};
    oorVecs[4] = '{3'd4, 32'hDEAD_BEEF, 1'b0};

    loadSweepData();
    for (int k = 0; k < 5; k++) inData5[k*32 +: 32] = 32'hA000_0000 + k;
    inData5[4*32 +: 32] = 32'hDEAD_BEEF;
    inSel5 = 3'd0; inValid5 = 1'b0; outReady5 = 1'b1;

    // Reset held two cycles with a valid producer.
    resetN = 1'b0;
    applyStimulus(1'b1, 3'd2, 1'b1);
    tick();
    tick();
    checkOutput("rst_out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, inReady}, 32'd0);
    checkOutput("rst_out_data", outData, 32'd0);
    checkOutput("rst_out_err", {31'b0, outErr}, 32'd0);
    resetN = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b1);
    #1;
    checkOutput("rel_in_ready", {31'b0, inReady}, 32'd1);
    tick();
    checkOutput("rel_out_valid", {31'b0, outValid}, 32'd0);

    // Select sweep, streaming one word per cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, sweepVecs[i].sel, 1'b1);
      checkOutput($sformatf("sweep%0d_in_ready", i), {31'b0, inReady}, 32'd1);
      tick();
      checkOutput($sformatf("sweep%0d_valid", i), {31'b0, outValid}, 32'd1);
      checkOutput($sformatf("sweep%0d_data", i), outData, sweepVecs[i].expData);
      checkOutput($sformatf("sweep%0d_err", i), {31'b0, outErr}, {31'b0, sweepVecs[i].expErr});
    end
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("sweep_drain_valid", {31'b0, outValid}, 32'd0);

    // Out-of-range selects on the 5-input instance.
    for (int i = 0; i < 5; i++) begin
      inValid5 = 1'b1;
      inSel5   = oorVecs[i].sel;
      tick();
      checkOutput($sformatf("oor%0d_valid", i), {31'b0, outValid5}, 32'd1);
      checkOutput($sformatf("oor%0d_data", i), outData5, oorVecs[i].expData);
      checkOutput($sformatf("oor%0d_err", i), {31'b0, outErr5}, {31'b0, oorVecs[i].expErr});
    end
    inValid5 = 1'b0;
    tick();
    checkOutput("oor_drain_valid", {31'b0, outValid5}, 32'd0);

    // Backpressure: A then B fill both slots, extra offer in FULL is ignored.
    applyStimulus(1'b1, 3'd1, 1'b0);
    tick();
    checkOutput("bp_A_data", outData, 32'h1000_0001);
    checkOutput("bp_A_in_ready", {31'b0, inReady}, 32'd1);
    applyStimulus(1'b1, 3'd2, 1'b0);
    tick();
    checkOutput("bp_full_in_ready", {31'b0, inReady}, 32'd0);
    checkOutput("bp_full_data", outData, 32'h1000_0001);
    applyStimulus(1'b1, 3'd5, 1'b0);
    tick();
    checkOutput("bp_hold_data", outData, 32'h1000_0001);
    checkOutput("bp_hold_valid", {31'b0, outValid}, 32'd1);
    checkOutput("bp_hold_in_ready", {31'b0, inReady}, 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("bp_B_data", outData, 32'h1000_0002);
    checkOutput("bp_B_valid", {31'b0, outValid}, 32'd1);
    tick();
    checkOutput("bp_drain_valid", {31'b0, outValid}, 32'd0);

    // Random streaming against a FIFO model.
    sent = 0; received = 0; cycles = 0;
    while ((sent < 100 || sbQ.size() != 0 || outValid) && cycles < 3000) begin
      for (int k = 0; k < 8; k++) inData[k*32 +: 32] = $urandom;
      inValid  = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      inSel    = 3'($urandom_range(0, 7));
      outReady = 1'($urandom_range(0, 3) != 0);
      acc = inValid & inReady;
      pop = outValid & outReady;
      if (pop) begin
        if (sbQ.size() == 0) begin
          checkOutput("stream_unexpected_word", outData, 32'hxxxx_xxxx);
        end else begin
          expWord = sbQ.pop_front();
          checkOutput($sformatf("stream%0d_data", received), outData, expWord[31:0]);
          checkOutput($sformatf("stream%0d_err", received), {31'b0, outErr}, {31'b0, expWord[32]});
          received++;
        end
      end
      if (acc) begin
        sbQ.push_back({1'b0, inData[inSel*32 +: 32]});
        sent++;
      end
      tick();
      cycles++;
    end
    checkOutput("stream_received", received, 32'd100);
    checkOutput("stream_in_flight", sbQ.size(), 32'd0);
    checkOutput("stream_end_valid", {31'b0, outValid}, 32'd0);

    // Reset while FULL discards both buffered words.
    loadSweepData();
    applyStimulus(1'b1, 3'd6, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd7, 1'b0);
    tick();
    checkOutput("rf_full_in_ready", {31'b0, inReady}, 32'd0);
    resetN = 1'b0;
    applyStimulus(1'b1, 3'd3, 1'b0);
    tick();
    resetN = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b1);
    #1;
    checkOutput("rf_out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rf_in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("rf_out_data", outData, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rf_quiet%0d_valid", i), {31'b0, outValid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
